ceespu_memory_stage: RTL and testbench
======================================

Name: ceespu_memory_stage

Overview:
- Pipeline stage after execute. Receives each instruction's memory request and writeback controls from the execute stage.
- Drives a request/acknowledge data bus, stalls the pipeline until the bus acknowledges, then aligns and extends load data.
- Produces the final writeback value, destination register and write enable for the register file.

Parameters:
- ACK_TIMEOUT, 255: maximum cycles spent waiting for I_busAck before the access is aborted and O_busErr pulses. A value of 0 disables the timeout.

Ports:
- I_clk  input  1  clock
- I_rst  input  1  synchronous active-high reset
- I_memE  input  1  instruction performs a memory access this cycle
- I_memWe  input  4  byte-lane write enables; 0 means load
- I_memAddress  input  32  byte address of the access
- I_storeData  input  32  lane-replicated store data
- I_selMem  input  3  access size in [1:0]: 0 word, 1 half, 2 byte. Bit 2 selects zero-extend, else sign-extend.
- I_we  input  1  instruction writes a register
- I_selWb  input  2  writeback source: 0 ALU, 1 load data, 2 link (PC+1), 3 ALU
- I_aluResult  input  32  ALU result
- I_PC  input  14  instruction PC
- I_regD  input  5  destination register
- I_busAck  input  1  bus completes the outstanding access
- I_busRdata  input  32  read data, valid with I_busAck
- O_busReq  output  1  access outstanding
- O_busAddr  output  32  word address; {I_memAddress[31:2],2'b00}
- O_busWdata  output  32  store data
- O_busWe  output  4  byte enables
- O_busy  output  1  pipeline stall request
- O_busErr  output  1  one-cycle pulse on timeout abort
- O_we  output  1  register-file write enable
- O_regD  output  5  register-file destination
- O_wbData  output  32  register-file write data

Behaviour:
- Reset values: all outputs 0 and state IDLE. The reset dominates any other event.
- Reset during WAIT drops O_busReq on the next edge, suppresses writeback and ignores a late ack.
- States: IDLE and WAIT.
- IDLE with I_memE=0:
  - Latch I_we, I_regD and O_wbData as selected by I_selWb, registered with 1-cycle latency.
  - Link value is {18'b0, I_PC} + 1, truncated to 32 bits.
- IDLE with I_memE=1:
  - Latch address, store data, byte enables, I_selMem, I_selWb, I_we, I_regD, ALU result and PC.
  - Assert O_busReq and move to WAIT.
  - O_we=0 during this cycle.
- WAIT behaviour:
  - O_busReq stays high. O_busAddr, O_busWdata and O_busWe hold their latched values.
  - O_busy = (state==WAIT) && !I_busAck, combinational. Upstream holds its inputs while O_busy=1, and this block ignores them.
- WAIT with I_busAck=1:
  - Capture I_busRdata, drop O_busReq and return to IDLE on the same edge.
  - O_we = latched we for exactly one cycle. O_wbData = load data if selWb=1, else ALU or link.
  - The next instruction is accepted in the cycle after the return to IDLE.
- Load alignment uses the latched address bits a[1:0]:
  - byte: lane a[1:0], e.g. a=3 → rdata[31:24].
  - half: upper half rdata[31:16] if a[0]=1, else rdata[15:0]. This matches the store-side enable rule of 1100 for an odd address.
  - word: rdata unchanged.
- Extension:
  - selMem[2]=0 sign-extends from bit 7 or 15.
  - selMem[2]=1 zero-extends.
- Stores (I_memWe≠0) complete on ack. Read data is ignored; O_we follows the latched we, normally 0.
- Timeout counter:
  - Cleared on entry to WAIT and increments each WAIT cycle without ack.
  - When it reaches ACK_TIMEOUT without ack:
    - Drop O_busReq and pulse O_busErr for one cycle.
    - Return to IDLE with O_we=0; O_busy falls.
  - If the ack arrives in the same cycle the count reaches ACK_TIMEOUT, the ack wins.
- I_busAck in IDLE is ignored.

Test Plan:
- ALU pass-through: I_memE=0, I_we=1, selWb=0, aluResult=0x1234_5678, regD=7 → next cycle O_we=1, O_regD=7, O_wbData=0x12345678, O_busReq=0.
- Signed byte load: address 0x103, selMem=3'b010, ack after 3 wait cycles with rdata=0x80FF_0000 → O_busAddr=0x100; O_busy high for 3 cycles; then O_wbData=0xFFFF_FF80 and a one-cycle O_we.
- Unsigned half load: address 0x41, selMem=3'b101, immediate ack with rdata=0xBEEF_1234 → O_wbData=0x0000_BEEF.
- Store: I_memWe=4'b0011, storeData=0xAAAA_AAAA, I_we=0 → O_busWe=0011 and O_busWdata=0xAAAAAAAA held until ack; no register write.
- Timeout: ACK_TIMEOUT=4 with no ack → O_busErr pulses after 4 WAIT cycles, O_busReq and O_busy drop, O_we stays 0. A later ack is ignored.
- Reset mid-WAIT: I_rst asserted in the second WAIT cycle, with ack in the same cycle → all outputs 0 next cycle and no writeback.

Source files
------------

// File: rtl/ceespu_memory_stage.sv
// Memory stage: issues one bus access per memory instruction, stalls until ack or timeout,
// then aligns/extends load data and registers the writeback value, destination and enable.
module ceespu_memory_stage #(
   parameter int ACK_TIMEOUT = 255
) (
   input  logic        I_clk,
   input  logic        I_rst,
   input  logic        I_memE,
   input  logic [3:0]  I_memWe,
   input  logic [31:0] I_memAddress,
   input  logic [31:0] I_storeData,
   input  logic [2:0]  I_selMem,
   input  logic        I_we,
   input  logic [1:0]  I_selWb,
   input  logic [31:0] I_aluResult,
   input  logic [13:0] I_PC,
   input  logic [4:0]  I_regD,
   input  logic        I_busAck,
   input  logic [31:0] I_busRdata,
   output logic        O_busReq,
   output logic [31:0] O_busAddr,
   output logic [31:0] O_busWdata,
   output logic [3:0]  O_busWe,
   output logic        O_busy,
   output logic        O_busErr,
   output logic        O_we,
   output logic [4:0]  O_regD,
   output logic [31:0] O_wbData
);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
   localparam logic [CNT_W:0] TIMEOUT_LIM = (CNT_W + 1)'(ACK_TIMEOUT);

   state_t             state_q,     state_d;
   logic               bus_req_q,   bus_req_d;
   logic [31:0]        bus_addr_q,  bus_addr_d;
   logic [31:0]        bus_wdata_q, bus_wdata_d;
   logic [3:0]         bus_we_q,    bus_we_d;
   logic               bus_err_q,   bus_err_d;
   logic               we_q,        we_d;
   logic [4:0]         reg_d_q,     reg_d_d;
   logic [31:0]        wb_data_q,   wb_data_d;
   logic [1:0]         addr_lo_q,   addr_lo_d;
   logic [2:0]         sel_mem_q,   sel_mem_d;
   logic [1:0]         sel_wb_q,    sel_wb_d;
   logic               lat_we_q,    lat_we_d;
   logic [31:0]        alu_q,       alu_d;
   logic [31:0]        link_q,      link_d;
   logic [CNT_W-1:0]   cnt_q,       cnt_d;

   logic [CNT_W:0]     cnt_inc;
   logic               timeout_hit;
   logic [31:0]        link_now;

   // The loaded byte/half is picked from the lane the byte address points at.
   function automatic logic [31:0] align_load(input logic [31:0] rdata,
                                              input logic [1:0]  a,
                                              input logic [2:0]  sel);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (a)
         2'd0:    b = rdata[7:0];
         2'd1:    b = rdata[15:8];
         2'd2:    b = rdata[23:16];
         default: b = rdata[31:24];
      endcase
      h = a[0] ? rdata[31:16] : rdata[15:0];
      case (sel[1:0])
         2'd1:    r = sel[2] ? {16'b0, h} : {{16{h[15]}}, h};
         2'd2:    r = sel[2] ? {24'b0, b} : {{24{b[7]}}, b};
         default: r = rdata;
      endcase
      return r;
   endfunction

   assign link_now    = {18'b0, I_PC} + 32'd1;
   assign cnt_inc     = {1'b0, cnt_q} + 1'b1;
   assign timeout_hit = (ACK_TIMEOUT != 0) && (cnt_inc == TIMEOUT_LIM);

   always_comb begin
      // NOTE: every _d gets a default first so no path through the case leaves it unassigned (no latches).
      state_d     = state_q;
      bus_req_d   = bus_req_q;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      bus_we_d    = bus_we_q;
      bus_err_d   = 1'b0;
      we_d        = we_q;
      reg_d_d     = reg_d_q;
      wb_data_d   = wb_data_q;
      addr_lo_d   = addr_lo_q;
      sel_mem_d   = sel_mem_q;
      sel_wb_d    = sel_wb_q;
      lat_we_d    = lat_we_q;
      alu_d       = alu_q;
      link_d      = link_q;
      cnt_d       = cnt_q;

      case (state_q)
         S_IDLE: begin
            if (I_memE) begin
               state_d     = S_WAIT;
               bus_req_d   = 1'b1;
               bus_addr_d  = {I_memAddress[31:2], 2'b00};
               bus_wdata_d = I_storeData;
               bus_we_d    = I_memWe;
               addr_lo_d   = I_memAddress[1:0];
               sel_mem_d   = I_selMem;
               sel_wb_d    = I_selWb;
               lat_we_d    = I_we;
               reg_d_d     = I_regD;
               alu_d       = I_aluResult;
               link_d      = link_now;
               cnt_d       = '0;
               we_d        = 1'b0;
            end else begin
               we_d      = I_we;
               reg_d_d   = I_regD;
               wb_data_d = (I_selWb == 2'd2) ? link_now : I_aluResult;
            end
         end
         S_WAIT: begin
            // Ack is tested before the timeout so a same-cycle ack still completes.
            if (I_busAck) begin
               state_d   = S_IDLE;
               bus_req_d = 1'b0;
               we_d      = lat_we_q;
               case (sel_wb_q)
                  2'd1:    wb_data_d = align_load(I_busRdata, addr_lo_q, sel_mem_q);
                  2'd2:    wb_data_d = link_q;
                  default: wb_data_d = alu_q;
               endcase
            end else if (timeout_hit) begin
               state_d   = S_IDLE;
               bus_req_d = 1'b0;
               bus_err_d = 1'b1;
               we_d      = 1'b0;
            end else if (ACK_TIMEOUT != 0) begin
               cnt_d = cnt_inc[CNT_W-1:0];
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         state_q     <= S_IDLE;
         bus_req_q   <= 1'b0;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
         bus_we_q    <= '0;
         bus_err_q   <= 1'b0;
         we_q        <= 1'b0;
         reg_d_q     <= '0;
         wb_data_q   <= '0;
         addr_lo_q   <= '0;
         sel_mem_q   <= '0;
         sel_wb_q    <= '0;
         lat_we_q    <= 1'b0;
         alu_q       <= '0;
         link_q      <= '0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         bus_req_q   <= bus_req_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         bus_we_q    <= bus_we_d;
         bus_err_q   <= bus_err_d;
         we_q        <= we_d;
         reg_d_q     <= reg_d_d;
         wb_data_q   <= wb_data_d;
         addr_lo_q   <= addr_lo_d;
         sel_mem_q   <= sel_mem_d;
         sel_wb_q    <= sel_wb_d;
         lat_we_q    <= lat_we_d;
         alu_q       <= alu_d;
         link_q      <= link_d;
         cnt_q       <= cnt_d;
      end
   end

   assign O_busReq   = bus_req_q;
   assign O_busAddr  = bus_addr_q;
   assign O_busWdata = bus_wdata_q;
   assign O_busWe    = bus_we_q;
   assign O_busErr   = bus_err_q;
   assign O_we       = we_q;
   assign O_regD     = reg_d_q;
   assign O_wbData   = wb_data_q;
   assign O_busy     = (state_q == S_WAIT) && !I_busAck;

endmodule

// File: tb/tb_ceespu_memory_stage.sv
// Directed bench for ceespu_memory_stage: pass-through, loads, store, timeout and reset-in-WAIT.
module tb_ceespu_memory_stage;

   logic        I_clk = 1'b0;
   logic        I_rst;
   logic        I_memE;
   logic [3:0]  I_memWe;
   logic [31:0] I_memAddress;
   logic [31:0] I_storeData;
   logic [2:0]  I_selMem;
   logic        I_we;
   logic [1:0]  I_selWb;
   logic [31:0] I_aluResult;
   logic [13:0] I_PC;
   logic [4:0]  I_regD;
   logic        I_busAck;
   logic [31:0] I_busRdata;
   logic        O_busReq;
   logic [31:0] O_busAddr;
   logic [31:0] O_busWdata;
   logic [3:0]  O_busWe;
   logic        O_busy;
   logic        O_busErr;
   logic        O_we;
   logic [4:0]  O_regD;
   logic [31:0] O_wbData;

   int n_cmp = 0;
   int n_err = 0;

   ceespu_memory_stage #(.ACK_TIMEOUT(4)) dut (
      .I_clk(I_clk), .I_rst(I_rst), .I_memE(I_memE), .I_memWe(I_memWe),
      .I_memAddress(I_memAddress), .I_storeData(I_storeData), .I_selMem(I_selMem),
      .I_we(I_we), .I_selWb(I_selWb), .I_aluResult(I_aluResult), .I_PC(I_PC),
      .I_regD(I_regD), .I_busAck(I_busAck), .I_busRdata(I_busRdata),
      .O_busReq(O_busReq), .O_busAddr(O_busAddr), .O_busWdata(O_busWdata),
      .O_busWe(O_busWe), .O_busy(O_busy), .O_busErr(O_busErr), .O_we(O_we),
      .O_regD(O_regD), .O_wbData(O_wbData)
   );

   always #5 I_clk = ~I_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge I_clk);
      #1;
   endtask

   task automatic idle_inputs();
      I_memE = 1'b0; I_memWe = 4'h0; I_memAddress = 32'h0; I_storeData = 32'h0;
      I_selMem = 3'b000; I_we = 1'b0; I_selWb = 2'd0; I_aluResult = 32'h0;
      I_PC = 14'h0; I_regD = 5'd0; I_busAck = 1'b0; I_busRdata = 32'h0;
   endtask

   // Junk on the upstream inputs while stalled must have no effect.
   task automatic scramble_inputs();
      I_memE = 1'b0; I_we = 1'b0; I_regD = 5'd31; I_aluResult = 32'hDEAD_BEEF;
      I_storeData = 32'h5555_5555; I_memAddress = 32'hFFFF_FFFF; I_memWe = 4'hF;
      I_selWb = 2'd0; I_selMem = 3'b000;
   endtask

   initial begin
      idle_inputs();
      I_rst = 1'b1;
      tick();
      tick();
      check("rst_busreq", 32'(O_busReq), 32'h0);
      check("rst_we",     32'(O_we),     32'h0);
      check("rst_wbdata", O_wbData,      32'h0);
      check("rst_buserr", 32'(O_busErr), 32'h0);
      check("rst_busy",   32'(O_busy),   32'h0);
      I_rst = 1'b0;

      // ALU pass-through
      I_we = 1'b1; I_selWb = 2'd0; I_aluResult = 32'h1234_5678; I_regD = 5'd7;
      tick();
      check("alu_we",     32'(O_we),     32'h1);
      check("alu_regd",   32'(O_regD),   32'd7);
      check("alu_wbdata", O_wbData,      32'h1234_5678);
      check("alu_busreq", 32'(O_busReq), 32'h0);

      // Link value wraps PC 0x3FFF to 0x4000
      I_selWb = 2'd2; I_PC = 14'h3FFF; I_regD = 5'd3;
      tick();
      check("link_wbdata", O_wbData, 32'h0000_4000);
      check("link_regd",   32'(O_regD), 32'd3);

      // selWb=3 is ALU
      I_selWb = 2'd3; I_aluResult = 32'hCAFE_0001;
      tick();
      check("sel3_wbdata", O_wbData, 32'hCAFE_0001);
      idle_inputs();
      tick();
      check("idle_we", 32'(O_we), 32'h0);

      // Signed byte load, ack on 4th WAIT cycle (same cycle the count reaches the limit)
      I_memE = 1'b1; I_memAddress = 32'h0000_0103; I_selMem = 3'b010;
      I_we = 1'b1; I_selWb = 2'd1; I_regD = 5'd9;
      tick();
      scramble_inputs();
      check("lb_busreq", 32'(O_busReq), 32'h1);
      check("lb_busaddr", O_busAddr, 32'h0000_0100);
      check("lb_we_accept", 32'(O_we), 32'h0);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("lb_busy%0d", i), 32'(O_busy), 32'h1);
         tick();
      end
      I_busAck = 1'b1; I_busRdata = 32'h80FF_0000;
      #1;
      check("lb_busy_ack", 32'(O_busy), 32'h0);
      check("lb_buserr_ack", 32'(O_busErr), 32'h0);
      tick();
      I_busAck = 1'b0; I_busRdata = 32'h0;
      check("lb_wbdata", O_wbData, 32'hFFFF_FF80);
      check("lb_we", 32'(O_we), 32'h1);
      check("lb_regd", 32'(O_regD), 32'd9);
      check("lb_busreq_done", 32'(O_busReq), 32'h0);
      check("lb_buserr", 32'(O_busErr), 32'h0);
      idle_inputs();
      tick();
      check("lb_we_pulse", 32'(O_we), 32'h0);

      // Unsigned half load from odd address, immediate ack
      I_memE = 1'b1; I_memAddress = 32'h0000_0041; I_selMem = 3'b101;
      I_we = 1'b1; I_selWb = 2'd1; I_regD = 5'd4;
      tick();
      scramble_inputs();
      check("lhu_busaddr", O_busAddr, 32'h0000_0040);
      I_busAck = 1'b1; I_busRdata = 32'hBEEF_1234;
      #1;
      check("lhu_busy_ack", 32'(O_busy), 32'h0);
      tick();
      idle_inputs();
      check("lhu_wbdata", O_wbData, 32'h0000_BEEF);
      check("lhu_we", 32'(O_we), 32'h1);
      tick();

      // Store: enables and data held until ack, no register write
      I_memE = 1'b1; I_memWe = 4'b0011; I_memAddress = 32'h0000_0200;
      I_storeData = 32'hAAAA_AAAA; I_we = 1'b0; I_selWb = 2'd0; I_regD = 5'd2;
      tick();
      scramble_inputs();
      for (int i = 0; i < 2; i++) begin
         check($sformatf("st_buswe%0d", i), 32'(O_busWe), 32'h3);
         check($sformatf("st_wdata%0d", i), O_busWdata, 32'hAAAA_AAAA);
         check($sformatf("st_req%0d", i), 32'(O_busReq), 32'h1);
         tick();
      end
      I_busAck = 1'b1; I_busRdata = 32'h1111_1111;
      tick();
      idle_inputs();
      check("st_we", 32'(O_we), 32'h0);
      check("st_busreq", 32'(O_busReq), 32'h0);
      tick();

      // Timeout after 4 WAIT cycles without ack
      I_memE = 1'b1; I_memAddress = 32'h0000_0300; I_selMem = 3'b000;
      I_we = 1'b1; I_selWb = 2'd1; I_regD = 5'd6;
      tick();
      scramble_inputs();
      for (int i = 0; i < 4; i++) begin
         check($sformatf("to_busy%0d", i), 32'(O_busy), 32'h1);
         check($sformatf("to_err%0d", i), 32'(O_busErr), 32'h0);
         check($sformatf("to_req%0d", i), 32'(O_busReq), 32'h1);
         tick();
      end
      idle_inputs();
      check("to_buserr", 32'(O_busErr), 32'h1);
      check("to_busreq", 32'(O_busReq), 32'h0);
      check("to_busy",   32'(O_busy),   32'h0);
      check("to_we",     32'(O_we),     32'h0);
      I_busAck = 1'b1; I_busRdata = 32'h7777_7777;
      tick();
      I_busAck = 1'b0;
      check("to_err_pulse", 32'(O_busErr), 32'h0);
      check("to_late_we", 32'(O_we), 32'h0);
      check("to_late_req", 32'(O_busReq), 32'h0);
      tick();

      // Reset during the second WAIT cycle with a simultaneous ack
      I_memE = 1'b1; I_memAddress = 32'h0000_0104; I_selMem = 3'b000;
      I_we = 1'b1; I_selWb = 2'd1; I_regD = 5'd5; I_memWe = 4'h0;
      tick();
      scramble_inputs();
      check("rw_busy1", 32'(O_busy), 32'h1);
      tick();
      I_rst = 1'b1; I_busAck = 1'b1; I_busRdata = 32'h1122_3344;
      tick();
      I_rst = 1'b0; I_busAck = 1'b0;
      idle_inputs();
      #1;
      check("rw_busreq", 32'(O_busReq), 32'h0);
      check("rw_busaddr", O_busAddr, 32'h0);
      check("rw_we", 32'(O_we), 32'h0);
      check("rw_regd", 32'(O_regD), 32'h0);
      check("rw_wbdata", O_wbData, 32'h0);
      check("rw_buserr", 32'(O_busErr), 32'h0);
      check("rw_busy", 32'(O_busy), 32'h0);
      I_busAck = 1'b1;
      tick();
      I_busAck = 1'b0;
      check("rw_late_we", 32'(O_we), 32'h0);
      check("rw_late_req", 32'(O_busReq), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
